// File: rtl/sync_link_ctrl.sv
// ============================================================================
// Module      : sync_link_ctrl
// Description : Link bring-up controller for the PCS receive Synchronization
//               block. It pulses the block's reset, waits for code sync with
//               a timeout, and qualifies sync as stable before declaring the
//               link up. It also retries a bounded number of times and counts
//               loss-of-sync events seen while the link is up.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_link_ctrl #(
  parameter int HOLD_CYC    = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int STABLE_CYC  = 16,
  parameter int MAX_RETRY   = 7,
  parameter int CNT_W       = 16
) (
  input  logic       Clk,
  input  logic       mr_main_reset,
  input  logic       enable,
  input  logic       code_sync_status,
  output logic       sync_rst,
  output logic       link_up,
  output logic       link_fail,
  output logic [7:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [2:0] ctrl_state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RESET_SYNC = 3'd1,
    WAIT_SYNC  = 3'd2,
    QUALIFY    = 3'd3,
    LINK_UP    = 3'd4,
    FAILED     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMER_ZERO   = '0;
  localparam logic [CNT_W-1:0] TIMER_ONE    = CNT_W'(1);
  localparam logic [7:0]       RETRY_LAST   = 8'(MAX_RETRY);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_n;
  logic [7:0]       retry_n;
  logic [7:0]       loss_n;

  // State, timer and counters; async reset returns everything to power-up values
  always_ff @(posedge Clk or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      state     <= IDLE;
      timer     <= TIMER_ZERO;
      retry_cnt <= 8'd0;
      loss_cnt  <= 8'd0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      retry_cnt <= retry_n;
      loss_cnt  <= loss_n;
    end
  end

  // Next-state, timer and counter logic; enable low overrides all transitions
  always_comb begin
    state_n = state;
    timer_n = timer;
    retry_n = retry_cnt;
    loss_n  = loss_cnt;
    case (state)
      IDLE: begin
        if (enable) begin
          state_n = RESET_SYNC;
          timer_n = TIMER_ZERO;
        end
      end
      RESET_SYNC: begin
        if (timer == HOLD_LAST) begin
          state_n = WAIT_SYNC;
          timer_n = TIMER_ZERO;
        end else begin
          timer_n = timer + TIMER_ONE;
        end
      end
      WAIT_SYNC: begin
        // Sync arriving on the timeout cycle still counts as success
        if (code_sync_status) begin
          state_n = QUALIFY;
          timer_n = TIMER_ZERO;
        end else if (timer == TIMEOUT_LAST) begin
          timer_n = TIMER_ZERO;
          if (retry_cnt == RETRY_LAST) begin
            state_n = FAILED;
          end else begin
            state_n = RESET_SYNC;
            retry_n = retry_cnt + 8'd1;
          end
        end else begin
          timer_n = timer + TIMER_ONE;
        end
      end
      QUALIFY: begin
        // A glitch restarts the wait without consuming a retry
        if (!code_sync_status) begin
          state_n = WAIT_SYNC;
          timer_n = TIMER_ZERO;
        end else if (timer == STABLE_LAST) begin
          state_n = LINK_UP;
          timer_n = TIMER_ZERO;
          retry_n = 8'd0;
        end else begin
          timer_n = timer + TIMER_ONE;
        end
      end
      LINK_UP: begin
        // The sync block recovers by itself, so no reset pulse on loss
        if (!code_sync_status) begin
          state_n = WAIT_SYNC;
          timer_n = TIMER_ZERO;
          if (loss_cnt != 8'hFF) begin
            loss_n = loss_cnt + 8'd1;
          end
        end
      end
      FAILED: begin
        state_n = FAILED;
      end
      default: begin
        state_n = IDLE;
        timer_n = TIMER_ZERO;
        retry_n = 8'd0;
      end
    endcase

    if (!enable && (state != IDLE)) begin
      state_n = IDLE;
      timer_n = TIMER_ZERO;
      retry_n = 8'd0;
      loss_n  = loss_cnt;
    end
  end

  // Registered Moore flags, decoded from the state being entered
  always_ff @(posedge Clk or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      sync_rst  <= 1'b1;
      link_up   <= 1'b0;
      link_fail <= 1'b0;
    end else begin
      sync_rst  <= (state_n == IDLE) || (state_n == RESET_SYNC) || (state_n == FAILED);
      link_up   <= (state_n == LINK_UP);
      link_fail <= (state_n == FAILED);
    end
  end

  assign ctrl_state = state;

endmodule

`default_nettype wire

// File: tb/tb_sync_link_ctrl.sv
// ============================================================================
// Module      : tb_sync_link_ctrl
// Description : Directed self-checking bench for sync_link_ctrl with
//               HOLD_CYC=4, TIMEOUT_CYC=32, STABLE_CYC=16, MAX_RETRY=2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_link_ctrl;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RESET   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_QUALIFY = 3'd3;
  localparam logic [2:0] S_LINKUP  = 3'd4;
  localparam logic [2:0] S_FAILED  = 3'd5;

  logic       Clk = 1'b0;
  logic       mr_main_reset;
  logic       enable;
  logic       code_sync_status;
  logic       sync_rst;
  logic       link_up;
  logic       link_fail;
  logic [7:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] ctrl_state;

  int n_checks = 0;
  int n_fail   = 0;

  sync_link_ctrl #(
    .HOLD_CYC   (4),
    .TIMEOUT_CYC(32),
    .STABLE_CYC (16),
    .MAX_RETRY  (2),
    .CNT_W      (16)
  ) dut (
    .Clk             (Clk),
    .mr_main_reset   (mr_main_reset),
    .enable          (enable),
    .code_sync_status(code_sync_status),
    .sync_rst        (sync_rst),
    .link_up         (link_up),
    .link_fail       (link_fail),
    .retry_cnt       (retry_cnt),
    .loss_cnt        (loss_cnt),
    .ctrl_state      (ctrl_state)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance n rising edges; sample and drive 1 time unit after the edge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic go_idle();
    enable = 1'b0;
    tick(1);
    check_eq("go_idle_state", {29'd0, ctrl_state}, {29'd0, S_IDLE});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mr_main_reset    = 1'b1;
    enable           = 1'b0;
    code_sync_status = 1'b0;
    tick(2);
    check_eq("rst_state",     {29'd0, ctrl_state}, {29'd0, S_IDLE});
    check_eq("rst_sync_rst",  {31'd0, sync_rst}, 32'd1);
    check_eq("rst_link_up",   {31'd0, link_up}, 32'd0);
    check_eq("rst_link_fail", {31'd0, link_fail}, 32'd0);
    check_eq("rst_retry",     {24'd0, retry_cnt}, 32'd0);
    check_eq("rst_loss",      {24'd0, loss_cnt}, 32'd0);
    mr_main_reset = 1'b0;
    tick(1);

    // Nominal bring-up
    enable = 1'b1;
    code_sync_status = 1'b1;
    tick(1);  // edge 1
    check_eq("nom_e1_state", {29'd0, ctrl_state}, {29'd0, S_RESET});
    check_eq("nom_e1_srst",  {31'd0, sync_rst}, 32'd1);
    tick(3);  // edge 4
    check_eq("nom_e4_srst",  {31'd0, sync_rst}, 32'd1);
    tick(1);  // edge 5
    check_eq("nom_e5_state", {29'd0, ctrl_state}, {29'd0, S_WAIT});
    check_eq("nom_e5_srst",  {31'd0, sync_rst}, 32'd0);
    tick(1);  // edge 6
    check_eq("nom_e6_state", {29'd0, ctrl_state}, {29'd0, S_QUALIFY});
    tick(15); // edge 21
    check_eq("nom_e21_link", {31'd0, link_up}, 32'd0);
    tick(1);  // edge 22
    check_eq("nom_e22_link", {31'd0, link_up}, 32'd1);
    check_eq("nom_e22_state", {29'd0, ctrl_state}, {29'd0, S_LINKUP});
    check_eq("nom_retry", {24'd0, retry_cnt}, 32'd0);

    // Loss after link-up
    code_sync_status = 1'b0;
    tick(1);
    check_eq("loss_link",  {31'd0, link_up}, 32'd0);
    check_eq("loss_cnt1",  {24'd0, loss_cnt}, 32'd1);
    check_eq("loss_srst",  {31'd0, sync_rst}, 32'd0);
    check_eq("loss_state", {29'd0, ctrl_state}, {29'd0, S_WAIT});
    code_sync_status = 1'b1;
    tick(16);
    check_eq("loss_requal", {31'd0, link_up}, 32'd0);
    tick(1);
    check_eq("loss_relink", {31'd0, link_up}, 32'd1);
    for (int r = 0; r < 300; r++) begin
      code_sync_status = 1'b0;
      tick(1);
      code_sync_status = 1'b1;
      tick(17);
    end
    check_eq("loss_sat", {24'd0, loss_cnt}, 32'd255);
    check_eq("loss_sat_link", {31'd0, link_up}, 32'd1);

    // Enable drop keeps loss_cnt; drop during QUALIFY goes to IDLE
    go_idle();
    check_eq("drop_loss_kept", {24'd0, loss_cnt}, 32'd255);
    enable = 1'b1;
    tick(6);
    check_eq("drop_q_state", {29'd0, ctrl_state}, {29'd0, S_QUALIFY});
    enable = 1'b0;
    tick(1);
    check_eq("drop_q_idle", {29'd0, ctrl_state}, {29'd0, S_IDLE});
    check_eq("drop_q_srst", {31'd0, sync_rst}, 32'd1);

    // Asynchronous reset while in LINK_UP
    enable = 1'b1;
    tick(22);
    check_eq("arst_pre_link", {31'd0, link_up}, 32'd1);
    #2;
    mr_main_reset = 1'b1;
    #1;
    check_eq("arst_link",  {31'd0, link_up}, 32'd0);
    check_eq("arst_srst",  {31'd0, sync_rst}, 32'd1);
    check_eq("arst_loss",  {24'd0, loss_cnt}, 32'd0);
    check_eq("arst_state", {29'd0, ctrl_state}, {29'd0, S_IDLE});
    enable = 1'b0;
    tick(1);
    mr_main_reset = 1'b0;
    tick(1);

    // Qualification glitch
    enable = 1'b1;
    code_sync_status = 1'b1;
    tick(6);
    check_eq("gl_q_state", {29'd0, ctrl_state}, {29'd0, S_QUALIFY});
    tick(10);
    code_sync_status = 1'b0;
    tick(1);
    check_eq("gl_wait", {29'd0, ctrl_state}, {29'd0, S_WAIT});
    code_sync_status = 1'b1;
    tick(1);
    check_eq("gl_requal", {29'd0, ctrl_state}, {29'd0, S_QUALIFY});
    tick(15);
    check_eq("gl_link_early", {31'd0, link_up}, 32'd0);
    tick(1);
    check_eq("gl_link", {31'd0, link_up}, 32'd1);
    check_eq("gl_retry", {24'd0, retry_cnt}, 32'd0);
    go_idle();

    // Timeout to failure: three attempts, each 4 reset + 32 wait cycles
    code_sync_status = 1'b0;
    enable = 1'b1;
    tick(1);
    for (int a = 0; a < 3; a++) begin
      check_eq("to_rst_state", {29'd0, ctrl_state}, {29'd0, S_RESET});
      tick(3);
      check_eq("to_rst_hold", {31'd0, sync_rst}, 32'd1);
      tick(1);
      check_eq("to_wait", {29'd0, ctrl_state}, {29'd0, S_WAIT});
      check_eq("to_wait_srst", {31'd0, sync_rst}, 32'd0);
      tick(31);
      check_eq("to_wait_end", {29'd0, ctrl_state}, {29'd0, S_WAIT});
      tick(1);
      if (a < 2) begin
        check_eq("to_retry", {24'd0, retry_cnt}, a + 1);
      end
    end
    check_eq("to_failed", {29'd0, ctrl_state}, {29'd0, S_FAILED});
    check_eq("to_fail_flag", {31'd0, link_fail}, 32'd1);
    check_eq("to_fail_retry", {24'd0, retry_cnt}, 32'd2);
    check_eq("to_fail_srst", {31'd0, sync_rst}, 32'd1);
    tick(5);
    check_eq("to_fail_hold", {31'd0, link_fail}, 32'd1);
    go_idle();
    check_eq("to_clr_fail", {31'd0, link_fail}, 32'd0);
    check_eq("to_clr_retry", {24'd0, retry_cnt}, 32'd0);

    // Retry then success
    enable = 1'b1;
    tick(5);
    check_eq("rs_wait", {29'd0, ctrl_state}, {29'd0, S_WAIT});
    tick(32);
    check_eq("rs_retry_state", {29'd0, ctrl_state}, {29'd0, S_RESET});
    code_sync_status = 1'b1;
    tick(4);
    check_eq("rs_retry1", {24'd0, retry_cnt}, 32'd1);
    tick(1);
    check_eq("rs_qual", {29'd0, ctrl_state}, {29'd0, S_QUALIFY});
    tick(16);
    check_eq("rs_link", {31'd0, link_up}, 32'd1);
    check_eq("rs_retry0", {24'd0, retry_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
